fft_delay_stage: RTL and testbench

FFT_DELAY_STAGE -- requirements
Module: fft_delay_stage

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_delay_line.sv | 36 +++
 rtl/fft_delay_stage.sv | 78 +++++++
 tb/tb_fft_delay_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fft_pkg -- shared defaults and constant helpers for the FFT pipeline. Rev 1.0
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int DEFAULT_SIZE  = 10;
  localparam int DEFAULT_DEPTH = 4;

  // Ceiling log2 of a positive value, usable in parameter and localparam context.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_delay_line.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fft_delay_line -- DEPTH-entry shift register that advances only on shift. Rev 1.0
// -----------------------------------------------------------------------------
module fft_delay_line
  import fft_pkg::*;
#(
  parameter int WIDTH = 2 * DEFAULT_SIZE,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (shift) begin
      r_mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign dout = r_mem[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fft_delay_stage.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fft_delay_stage -- SDF feedback delay, phase counter and valid/sof tagging. Rev 1.0
// Optional flush input enabled by defining FFT_DELAY_FLUSH_EN.
// -----------------------------------------------------------------------------
module fft_delay_stage
  import fft_pkg::*;
#(
  parameter int SIZE  = DEFAULT_SIZE,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef FFT_DELAY_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic signed [SIZE-1:0] in_re,
  input  logic signed [SIZE-1:0] in_im,
  input  logic                   in_valid,
  input  logic signed [SIZE-1:0] fb_re,
  input  logic signed [SIZE-1:0] fb_im,
  output logic signed [SIZE-1:0] dly_re,
  output logic signed [SIZE-1:0] dly_im,
  output logic                   sel,
  output logic                   out_valid,
  output logic                   out_sof
);

  localparam int CW = clog2(2 * DEPTH);
  localparam logic [CW-1:0] c_fill_last  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] c_first_bfly = CW'(DEPTH);

  logic            w_clear_n;
  logic [CW-1:0]   r_cnt;
  logic            r_primed;
  logic [2*SIZE-1:0] w_din;
  logic [2*SIZE-1:0] w_dout;

`ifdef FFT_DELAY_FLUSH_EN
  assign w_clear_n = rst_n & ~flush;
`else
  assign w_clear_n = rst_n;
`endif

  // Power-of-two frame length lets the counter wrap naturally with no bubble.
  always_ff @(posedge clk) begin
    if (!w_clear_n) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else if (in_valid) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == c_fill_last) begin
        r_primed <= 1'b1;
      end
    end
  end

  assign sel   = r_cnt[CW-1];
  assign w_din = sel ? {fb_re, fb_im} : {in_re, in_im};

  fft_delay_line #(
    .WIDTH (2 * SIZE),
    .DEPTH (DEPTH)
  ) u_line (
    .clk   (clk),
    .rst_n (w_clear_n),
    .shift (in_valid),
    .din   (w_din),
    .dout  (w_dout)
  );

  assign dly_re    = w_dout[2*SIZE-1:SIZE];
  assign dly_im    = w_dout[SIZE-1:0];
  assign out_valid = in_valid & r_primed;
  assign out_sof   = out_valid & (r_cnt == c_first_bfly);

endmodule
`default_nettype wire

// File: tb/tb_fft_delay_stage.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// tb_fft_delay_stage -- randomized and directed bench with a queue-based model. Rev 1.0
// -----------------------------------------------------------------------------
module tb_fft_delay_stage;

  localparam int SZ = 10;
  localparam int DP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [SZ-1:0] in_re = '0, in_im = '0, fb_re = '0, fb_im = '0;
  logic signed [SZ-1:0] dly_re, dly_im;
  logic                 sel, out_valid, out_sof;

  int total = 0;
  int bad   = 0;

  // Model: every value written since reset, preceded by DP zeros of cleared line.
  int                   m_cnt;
  int                   m_acc;
  logic signed [SZ-1:0] q_re[$];
  logic signed [SZ-1:0] q_im[$];

  fft_delay_stage #(.SIZE(SZ), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FFT_DELAY_FLUSH_EN
    .flush     (flush),
`endif
    .in_re     (in_re),
    .in_im     (in_im),
    .in_valid  (in_valid),
    .fb_re     (fb_re),
    .fb_im     (fb_im),
    .dly_re    (dly_re),
    .dly_im    (dly_im),
    .sel       (sel),
    .out_valid (out_valid),
    .out_sof   (out_sof)
  );

  function automatic void model_reset();
    m_cnt = 0;
    m_acc = 0;
    q_re  = {};
    q_im  = {};
    for (int i = 0; i < DP; i++) begin
      q_re.push_back('0);
      q_im.push_back('0);
    end
  endfunction

  function automatic logic [2*SZ+2:0] expv();
    logic s, ov, sof;
    s   = (m_cnt >= DP);
    ov  = in_valid && (m_acc >= DP);
    sof = ov && (m_cnt == DP);
    return {s, ov, sof, q_re[q_re.size()-DP], q_im[q_im.size()-DP]};
  endfunction

  function automatic logic signed [SZ-1:0] rnd();
    logic signed [SZ-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = {1'b1, {(SZ-1){1'b0}}};
      1:       v = {1'b0, {(SZ-1){1'b1}}};
      default: v = SZ'($urandom);
    endcase
    return v;
  endfunction

  task automatic drive(input bit r, input bit v, input logic signed [SZ-1:0] ir,
                       input logic signed [SZ-1:0] ii, input logic signed [SZ-1:0] fr,
                       input logic signed [SZ-1:0] fi);
    @(negedge clk);
    rst_n = r; in_valid = v; in_re = ir; in_im = ii; fb_re = fr; fb_im = fi;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n || flush) begin
      model_reset();
    end else if (in_valid) begin
      if (m_cnt >= DP) begin
        q_re.push_back(fb_re); q_im.push_back(fb_im);
      end else begin
        q_re.push_back(in_re); q_im.push_back(in_im);
      end
      m_cnt = (m_cnt + 1) % (2 * DP);
      m_acc++;
    end
  endtask

  task automatic test_reset();
    drive(0, 1, rnd(), rnd(), rnd(), rnd());
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, rnd(), rnd(), rnd(), rnd());
      total++;
      if ({sel, out_valid, out_sof} !== 3'b000) begin
        bad++; $display("FAIL reset_flags cyc=%0d got=%b required=000", i, {sel, out_valid, out_sof});
      end
      total++;
      if (dly_re !== '0 || dly_im !== '0) begin
        bad++; $display("FAIL reset_dly cyc=%0d got=%0d/%0d required=0/0", i, dly_re, dly_im);
      end
      tick();
    end
  endtask

  task automatic test_fill_and_wrap();
    for (int k = 1; k <= 12; k++) begin
      drive(1, 1, SZ'(k), rnd(), SZ'(100 + m_cnt), rnd());
      total++;
      if ({sel, out_valid, out_sof, dly_re, dly_im} !== expv()) begin
        bad++; $display("FAIL fill_model k=%0d got=%h required=%h", k, {sel, out_valid, out_sof, dly_re, dly_im}, expv());
      end
      total++;
      if ((k <= 4 && (sel !== 1'b0 || out_valid !== 1'b0)) ||
          (k >= 5 && k <= 8 && (sel !== 1'b1 || out_valid !== 1'b1 || out_sof !== (k == 5) || dly_re !== SZ'(k - 4))) ||
          (k >= 9 && (sel !== 1'b0 || out_sof !== 1'b0 || dly_re !== SZ'(95 + k)))) begin
        bad++; $display("FAIL fill_directed k=%0d got sel=%b ov=%b sof=%b dly_re=%0d", k, sel, out_valid, out_sof, dly_re);
      end
      tick();
    end
  endtask

  task automatic test_gaps();
    int k;
    int n;
    bit v;
    drive(0, 0, rnd(), rnd(), rnd(), rnd());
    tick();
    k = 1;
    n = 0;
    while (k <= 12) begin
      v = (n % 4 == 0) || (n % 4 == 3);
      n++;
      drive(1, v, v ? SZ'(k) : rnd(), rnd(), v ? SZ'(100 + m_cnt) : rnd(), rnd());
      total++;
      if ({sel, out_valid, out_sof, dly_re, dly_im} !== expv()) begin
        bad++; $display("FAIL gap_model n=%0d got=%h required=%h", n, {sel, out_valid, out_sof, dly_re, dly_im}, expv());
      end
      total++;
      if ((!v && (out_valid !== 1'b0 || out_sof !== 1'b0)) ||
          (v && k >= 5 && k <= 8 && (sel !== 1'b1 || dly_re !== SZ'(k - 4) || out_sof !== (k == 5))) ||
          (v && k >= 9 && (sel !== 1'b0 || dly_re !== SZ'(95 + k)))) begin
        bad++; $display("FAIL gap_directed n=%0d k=%0d got sel=%b ov=%b sof=%b dly_re=%0d", n, k, sel, out_valid, out_sof, dly_re);
      end
      tick();
      if (v) k++;
    end
  endtask

  task automatic test_extremes();
    logic signed [SZ-1:0] lo, hi;
    lo = {1'b1, {(SZ-1){1'b0}}};
    hi = {1'b0, {(SZ-1){1'b1}}};
    drive(0, 0, rnd(), rnd(), rnd(), rnd());
    tick();
    for (int k = 1; k <= 6; k++) begin
      drive(1, 1, (k == 1) ? lo : (k == 2) ? hi : rnd(), (k == 1) ? hi : (k == 2) ? lo : rnd(), rnd(), rnd());
      total++;
      if ({sel, out_valid, out_sof, dly_re, dly_im} !== expv()) begin
        bad++; $display("FAIL extreme_model k=%0d got=%h required=%h", k, {sel, out_valid, out_sof, dly_re, dly_im}, expv());
      end
      if (k >= 5) begin
        total++;
        if ((k == 5 && (dly_re !== lo || dly_im !== hi)) || (k == 6 && (dly_re !== hi || dly_im !== lo))) begin
          bad++; $display("FAIL extreme_value k=%0d got=%0d/%0d", k, dly_re, dly_im);
        end
      end
      tick();
    end
  endtask

  task automatic test_midframe_reset();
    drive(0, 0, rnd(), rnd(), rnd(), rnd());
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, rnd(), rnd(), rnd(), rnd());
      tick();
    end
`ifdef FFT_DELAY_FLUSH_EN
    flush = 1'b1;
    drive(1, 1, rnd(), rnd(), rnd(), rnd());
    tick();
    @(negedge clk);
    flush = 1'b0;
`else
    drive(0, 1, rnd(), rnd(), rnd(), rnd());
    tick();
`endif
    for (int k = 1; k <= 8; k++) begin
      drive(1, 1, SZ'(k), rnd(), SZ'(100 + m_cnt), rnd());
      total++;
      if ((k <= 4 && (sel !== 1'b0 || out_valid !== 1'b0 || dly_re !== '0)) ||
          (k >= 5 && (sel !== 1'b1 || out_valid !== 1'b1 || out_sof !== (k == 5) || dly_re !== SZ'(k - 4)))) begin
        bad++; $display("FAIL midreset k=%0d got sel=%b ov=%b sof=%b dly_re=%0d", k, sel, out_valid, out_sof, dly_re);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int sofs;
    sofs = 0;
    drive(0, 0, rnd(), rnd(), rnd(), rnd());
    tick();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, rnd(), rnd(), rnd(), rnd());
      total++;
      if (rst_n && ({sel, out_valid, out_sof, dly_re, dly_im} !== expv())) begin
        bad++; $display("FAIL random_model i=%0d got=%h required=%h", i, {sel, out_valid, out_sof, dly_re, dly_im}, expv());
      end
      if (out_sof === 1'b1) sofs++;
      tick();
    end
    total++;
    if (sofs == 0) begin
      bad++; $display("FAIL random_sof_seen got=%0d required=>0", sofs);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_and_wrap();
    test_gaps();
    test_extremes();
    test_midframe_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
